// File: rtl/credit_receiver.sv
// credit_receiver: receive end of a credit-based link.
// Buffers words pushed by a credit-limited sender, presents them show-ahead on
// a ready/valid port, and returns one registered credit pulse per word drained.
// Optional macro CREDIT_RX_OVERFLOW_CHECK_EN adds a sticky overflow flag and
// drops an illegal push at full instead of corrupting the buffer.
module credit_receiver #(
    parameter int N_CREDITS  = 10,
    parameter int DATA_WIDTH = 32
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          i_valid,
    input  logic [DATA_WIDTH-1:0]         i_data,
    output logic                          o_valid,
    output logic [DATA_WIDTH-1:0]         o_data,
    input  logic                          i_ready,
    output logic                          o_credit_return,
    output logic [$clog2(N_CREDITS+1)-1:0] o_count,
    output logic                          o_overflow
);
    localparam int PW = $clog2(N_CREDITS);
    localparam int CW = $clog2(N_CREDITS+1);

    logic [DATA_WIDTH-1:0] mem [N_CREDITS];
    logic [PW-1:0]         wr_ptr, rd_ptr;
    logic [CW-1:0]         count;
    logic                  credit_q;
    logic                  push, pop;

    // Pop only when a word is actually presented; i_ready alone does nothing.
    assign pop = o_valid && i_ready;

`ifdef CREDIT_RX_OVERFLOW_CHECK_EN
    logic full;
    logic overflow_q;
    assign full = (count == CW'(N_CREDITS));
    // A push at full is only legal when the head leaves in the same cycle.
    assign push = i_valid && (!full || pop);
    assign o_overflow = overflow_q;

    // Sticky protocol-error flag; cleared only by reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            overflow_q <= 1'b0;
        else if (i_valid && full && !pop)
            overflow_q <= 1'b1;
    end
`else
    // Credits guarantee space, so every strobe is written unconditionally.
    assign push = i_valid;
    assign o_overflow = 1'b0;
`endif

    // Storage array; contents need no reset since count gates visibility.
    always_ff @(posedge clock) begin
        if (push)
            mem[wr_ptr] <= i_data;
    end

    // Pointers wrap by explicit compare so depth need not be a power of two.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push)
                wr_ptr <= (wr_ptr == PW'(N_CREDITS-1)) ? '0 : wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= (rd_ptr == PW'(N_CREDITS-1)) ? '0 : rd_ptr + 1'b1;
        end
    end

    // Occupancy: simultaneous push and pop leave it unchanged.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            count <= '0;
        else begin
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // One credit pulse the cycle after each pop; back-to-back pops stay distinct.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            credit_q <= 1'b0;
        else
            credit_q <= pop;
    end

    assign o_valid         = (count != '0);
    assign o_data          = mem[rd_ptr];
    assign o_count         = count;
    assign o_credit_return = credit_q;

endmodule

// File: tb/tb_credit_receiver.sv
// Scoreboard bench for credit_receiver: words are queued when pushed and
// compared in order as they are popped; credits and occupancy are modelled.
module tb_credit_receiver;
    localparam int N  = 10;
    localparam int DW = 32;
    localparam int CW = $clog2(N+1);

    logic          clock = 1'b0;
    logic          reset;
    logic          i_valid;
    logic [DW-1:0] i_data;
    logic          o_valid;
    logic [DW-1:0] o_data;
    logic          i_ready;
    logic          o_credit_return;
    logic [CW-1:0] o_count;
    logic          o_overflow;

    credit_receiver #(.N_CREDITS(N), .DATA_WIDTH(DW)) dut (
        .clock(clock), .reset(reset),
        .i_valid(i_valid), .i_data(i_data),
        .o_valid(o_valid), .o_data(o_data), .i_ready(i_ready),
        .o_credit_return(o_credit_return), .o_count(o_count),
        .o_overflow(o_overflow)
    );

    always #5 clock = ~clock;

    int            checks = 0;
    int            errors = 0;
    int            exp_count = 0;
    logic [DW-1:0] sb [$];

    // Drive one cycle of stimulus, update the model, and advance past the edge.
    // Returns whether the model expects a pop and what the DUT showed at o_data.
    task automatic tick(input logic v, input logic [DW-1:0] d, input logic r,
                        output logic popped, output logic [DW-1:0] pd);
        logic push_ok;
        @(negedge clock);
        i_valid = v; i_data = d; i_ready = r;
        #1;
        popped = (exp_count != 0) && r;
        pd = o_data;
`ifdef CREDIT_RX_OVERFLOW_CHECK_EN
        push_ok = v && ((exp_count < N) || popped);
`else
        push_ok = v;
`endif
        if (push_ok) sb.push_back(d);
        exp_count = exp_count + (push_ok ? 1 : 0) - (popped ? 1 : 0);
        @(posedge clock);
        #1;
    endtask

    task automatic test_reset();
        logic p; logic [DW-1:0] pd;
        reset = 1'b1; i_valid = 0; i_data = '0; i_ready = 0;
        #12;
        checks++;
        if (o_valid !== 1'b0 || o_count !== '0 || o_credit_return !== 1'b0 || o_overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_init: valid=%b count=%0d credit=%b ovf=%b expected 0/0/0/0",
                     o_valid, o_count, o_credit_return, o_overflow);
        end
        @(negedge clock); reset = 1'b0;
        // Build count=4 with a credit pulse pending, then reset mid-stream.
        for (int i = 0; i < 5; i++) tick(1'b1, DW'(32'hB0 + i), 1'b0, p, pd);
        tick(1'b0, '0, 1'b1, p, pd);
        checks++;
        if (o_count !== CW'(4) || o_credit_return !== 1'b1) begin
            errors++;
            $display("FAIL reset_pre: count=%0d credit=%b expected 4/1", o_count, o_credit_return);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (o_valid !== 1'b0 || o_count !== '0 || o_credit_return !== 1'b0) begin
            errors++;
            $display("FAIL reset_async: valid=%b count=%0d credit=%b expected 0/0/0",
                     o_valid, o_count, o_credit_return);
        end
        sb.delete(); exp_count = 0;
        @(negedge clock); reset = 1'b0; i_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick(1'b0, '0, 1'b1, p, pd);
            checks++;
            if (o_credit_return !== 1'b0 || o_count !== '0) begin
                errors++;
                $display("FAIL reset_after: credit=%b count=%0d expected 0/0", o_credit_return, o_count);
            end
        end
    endtask

    task automatic test_single();
        logic p; logic [DW-1:0] pd;
        tick(1'b1, DW'(32'hA5), 1'b1, p, pd);
        checks++;
        if (o_valid !== 1'b1 || o_data !== DW'(32'hA5) || o_count !== CW'(1) || o_credit_return !== 1'b0) begin
            errors++;
            $display("FAIL single_visible: valid=%b data=%h count=%0d credit=%b expected 1/a5/1/0",
                     o_valid, o_data, o_count, o_credit_return);
        end
        tick(1'b0, '0, 1'b1, p, pd);
        checks++;
        if (!p || pd !== sb[0]) begin
            errors++;
            $display("FAIL single_data: popped=%b got %h expected %h", p, pd, sb[0]);
        end
        if (p) void'(sb.pop_front());
        checks++;
        if (o_credit_return !== 1'b1 || o_count !== '0 || o_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_credit: credit=%b count=%0d valid=%b expected 1/0/0",
                     o_credit_return, o_count, o_valid);
        end
        tick(1'b0, '0, 1'b1, p, pd);
        checks++;
        if (o_credit_return !== 1'b0) begin
            errors++;
            $display("FAIL single_once: credit=%b expected 0", o_credit_return);
        end
    endtask

    task automatic test_fill_drain();
        logic p; logic [DW-1:0] pd; logic [DW-1:0] e;
        for (int i = 0; i < N; i++) tick(1'b1, DW'(i), 1'b0, p, pd);
        checks++;
        if (o_count !== CW'(N) || o_valid !== 1'b1) begin
            errors++;
            $display("FAIL fill_count: count=%0d valid=%b expected %0d/1", o_count, o_valid, N);
        end
        for (int i = 0; i < N; i++) begin
            tick(1'b0, '0, 1'b1, p, pd);
            e = sb.pop_front();
            checks++;
            if (pd !== e || o_credit_return !== 1'b1 || o_count !== CW'(exp_count)) begin
                errors++;
                $display("FAIL drain[%0d]: data=%h credit=%b count=%0d expected %h/1/%0d",
                         i, pd, o_credit_return, o_count, e, exp_count);
            end
        end
        tick(1'b0, '0, 1'b0, p, pd);
        checks++;
        if (o_credit_return !== 1'b0 || o_count !== '0) begin
            errors++;
            $display("FAIL drain_end: credit=%b count=%0d expected 0/0", o_credit_return, o_count);
        end
    endtask

    task automatic test_full_push_pop();
        logic p; logic [DW-1:0] pd; logic [DW-1:0] e;
        for (int i = 0; i < N; i++) tick(1'b1, DW'(32'h100 + i), 1'b0, p, pd);
        tick(1'b1, DW'(32'h55), 1'b1, p, pd);
        e = sb.pop_front();
        checks++;
        if (pd !== e || o_count !== CW'(N) || o_overflow !== 1'b0 || o_credit_return !== 1'b1) begin
            errors++;
            $display("FAIL full_pushpop: data=%h count=%0d ovf=%b credit=%b expected %h/%0d/0/1",
                     pd, o_count, o_overflow, o_credit_return, e, N);
        end
        for (int i = 0; i < N; i++) begin
            tick(1'b0, '0, 1'b1, p, pd);
            e = sb.pop_front();
            checks++;
            if (pd !== e) begin
                errors++;
                $display("FAIL full_order[%0d]: data=%h expected %h", i, pd, e);
            end
        end
        checks++;
        if (o_count !== '0 || o_overflow !== 1'b0) begin
            errors++;
            $display("FAIL full_end: count=%0d ovf=%b expected 0/0", o_count, o_overflow);
        end
    endtask

    task automatic test_wrap();
        logic p; logic [DW-1:0] pd; logic [DW-1:0] e;
        logic r, v;
        int pushed = 0, pops = 0, credits = 0, cyc = 0;
        while ((pushed < 25 || sb.size() != 0) && cyc < 500) begin
            r = 1'($urandom_range(0, 1));
            v = (pushed < 25) && ((exp_count < N) || (r && exp_count != 0));
            tick(v, DW'(32'hC00 + pushed), r, p, pd);
            if (v) pushed++;
            if (p) begin
                pops++;
                e = sb.pop_front();
                checks++;
                if (pd !== e) begin
                    errors++;
                    $display("FAIL wrap_data: got %h expected %h", pd, e);
                end
            end
            if (o_credit_return === 1'b1) credits++;
            checks++;
            if (o_count !== CW'(exp_count) || o_count > CW'(N)) begin
                errors++;
                $display("FAIL wrap_count: got %0d expected %0d", o_count, exp_count);
            end
            cyc++;
        end
        tick(1'b0, '0, 1'b0, p, pd);
        checks++;
        if (cyc >= 500 || pops != 25 || credits != pops) begin
            errors++;
            $display("FAIL wrap_total: cycles=%0d pops=%0d credits=%0d expected pops=25 credits=pops",
                     cyc, pops, credits);
        end
    endtask

`ifdef CREDIT_RX_OVERFLOW_CHECK_EN
    task automatic test_overflow();
        logic p; logic [DW-1:0] pd; logic [DW-1:0] e;
        for (int i = 0; i < N; i++) tick(1'b1, DW'(32'h200 + i), 1'b0, p, pd);
        tick(1'b1, DW'(32'hDEAD), 1'b0, p, pd);
        checks++;
        if (o_overflow !== 1'b1 || o_count !== CW'(N)) begin
            errors++;
            $display("FAIL ovf_set: ovf=%b count=%0d expected 1/%0d", o_overflow, o_count, N);
        end
        for (int i = 0; i < N; i++) begin
            tick(1'b0, '0, 1'b1, p, pd);
            e = sb.pop_front();
            checks++;
            if (pd !== e || o_overflow !== 1'b1) begin
                errors++;
                $display("FAIL ovf_keep[%0d]: data=%h ovf=%b expected %h/1", i, pd, o_overflow, e);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_fill_drain();
        test_full_push_pop();
        test_wrap();
`ifdef CREDIT_RX_OVERFLOW_CHECK_EN
        test_overflow();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
